// File: rtl/bnn_pkg.sv
// bnn_pkg: shared sizes and state encoding for the binary feature-map pipeline
package bnn_pkg;
  localparam int IMG_SIZE = 28;
  localparam int POOL_SIZE = 14;
  typedef enum logic {IDLE, SEND} unpool_state_t;
endpackage

// File: rtl/max_unpool_streamer_row_expand.sv
// unpool_row_expand: duplicates every bit of a pooled row into two adjacent output columns
module unpool_row_expand
  import bnn_pkg::*;
#(
  parameter int N = POOL_SIZE
) (
  input  logic [N-1:0]   pooled,
  output logic [2*N-1:0] row
);
  for (genvar c = 0; c < 2 * N; c++) begin : g_col
    assign row[c] = pooled[c/2];
  end
endmodule

// File: rtl/max_unpool_streamer.sv
// max_unpool_streamer: captures a pooled binary image and streams its 2x nearest-neighbour upsampling row by row
module max_unpool_streamer
  import bnn_pkg::*;
#(
  parameter int IMG_IN_SIZE  = POOL_SIZE,
  parameter int IMG_OUT_SIZE = 2 * IMG_IN_SIZE,
  parameter int ROW_IDX_W    = $clog2(IMG_OUT_SIZE)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [IMG_IN_SIZE*IMG_IN_SIZE-1:0] img_in,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [IMG_OUT_SIZE-1:0]            out_row,
  output logic [ROW_IDX_W-1:0]               out_row_idx,
  output logic                               out_valid,
  output logic                               out_last,
  input  logic                               out_ready,
  output logic                               done
);
  localparam logic [ROW_IDX_W-1:0] LAST = ROW_IDX_W'(IMG_OUT_SIZE - 1);
  unpool_state_t state, state_n;
  logic [IMG_IN_SIZE*IMG_IN_SIZE-1:0] img, img_n;
  logic [ROW_IDX_W-1:0] row, row_n;
  logic done_n;
  logic [IMG_IN_SIZE-1:0] pooled_rows [IMG_IN_SIZE];
  logic [IMG_IN_SIZE-1:0] pooled;
  logic [IMG_OUT_SIZE-1:0] expanded;
  for (genvar r = 0; r < IMG_IN_SIZE; r++) begin : g_prow
    assign pooled_rows[r] = img[r*IMG_IN_SIZE +: IMG_IN_SIZE];
  end
  // output row r comes from pooled row r/2
  assign pooled = pooled_rows[row[ROW_IDX_W-1:1]];
  unpool_row_expand #(.N(IMG_IN_SIZE)) u_expand (
    .pooled (pooled),
    .row    (expanded)
  );
  assign in_ready    = state == IDLE;
  assign out_valid   = state == SEND;
  assign out_row     = out_valid ? expanded : '0;
  assign out_row_idx = row;
  assign out_last    = out_valid && row == LAST;
  // next-state: capture in IDLE, advance the row counter on each output handshake
  always_comb begin
    state_n = state;
    img_n   = img;
    row_n   = row;
    done_n  = 1'b0;
    if (state == IDLE && in_valid) begin
      state_n = SEND;
      img_n   = img_in;
      row_n   = '0;
    end else if (state == SEND && out_ready) begin
      state_n = out_last ? IDLE : SEND;
      row_n   = out_last ? '0 : row + 1'b1;
      done_n  = out_last;
    end
  end
  // state, image, counter and done pulse registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      img   <= '0;
      row   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      img   <= img_n;
      row   <= row_n;
      done  <= done_n;
    end
  end
endmodule

// File: tb/tb_max_unpool_streamer.sv
// tb_max_unpool_streamer: table vectors, corner sequences and random images against a pixel-rule model
module tb_max_unpool_streamer;
  localparam int N = 14;
  localparam int M = 28;
  typedef logic [N*N-1:0] img_t;
  typedef struct {
    img_t        img;
    int          idx;
    logic [M-1:0] row;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  img_t img_in = '0;
  logic in_ready, out_valid, out_last, done;
  logic [M-1:0] out_row;
  logic [4:0] out_row_idx;
  int checks = 0;
  int errors = 0;
  logic [M-1:0] got_rows [M];
  vec_t tbl [$];
  always #5 clk = ~clk;
  max_unpool_streamer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .img_in      (img_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_row     (out_row),
    .out_row_idx (out_row_idx),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .done        (done)
  );
  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  function automatic logic [M-1:0] model_row(input img_t img, input int r);
    logic [M-1:0] m;
    for (int c = 0; c < M; c++) m[c] = img[(r / 2) * N + c / 2];
    return m;
  endfunction
  function automatic img_t rep_row(input logic [N-1:0] p);
    img_t i;
    for (int r = 0; r < N; r++) i[r*N +: N] = p;
    return i;
  endfunction
  function automatic img_t checkerboard();
    img_t i;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) i[r*N+c] = ((r + c) % 2) == 1;
    return i;
  endfunction
  function automatic img_t rand_img();
    img_t i;
    for (int k = 0; k < N * N; k++) i[k] = 1'($urandom_range(0, 1));
    return i;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_checks(input string tag);
    check({tag, "_in_ready"}, 256'(in_ready), 256'(1));
    check({tag, "_out_valid"}, 256'(out_valid), 256'(0));
    check({tag, "_done"}, 256'(done), 256'(0));
    check({tag, "_out_last"}, 256'(out_last), 256'(0));
    check({tag, "_out_row_idx"}, 256'(out_row_idx), 256'(0));
    check({tag, "_out_row"}, 256'(out_row), 256'(0));
  endtask
  task automatic send(input img_t img);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    check("accept_in_ready", 256'(in_ready), 256'(1));
    in_valid = 1'b1;
    img_in = img;
    tick();
    in_valid = 1'b0;
  endtask
  task automatic stream(input img_t img, input int stall_idx, input int stall_len,
                        input int inject_idx, input int abort_idx, input bit rnd, output int cyc);
    int r;
    int stalls;
    bit rdy;
    img_t pooled;
    r = 0;
    stalls = 0;
    cyc = 0;
    while (r < M && cyc < 300) begin
      check("out_valid", 256'(out_valid), 256'(1));
      check("in_ready_send", 256'(in_ready), 256'(0));
      check("out_row_idx", 256'(out_row_idx), 256'(r));
      check("out_row", 256'(out_row), 256'(model_row(img, r)));
      check("out_last", 256'(out_last), 256'(r == M - 1));
      check("done_low", 256'(done), 256'(0));
      got_rows[r] = out_row;
      if (r == abort_idx) begin
        rst_n = 1'b0;
        out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b0;
        idle_checks("abort");
        tick();
        check("abort_no_done", 256'(done), 256'(0));
        return;
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : !(r == stall_idx && stalls < stall_len);
      if (!rdy) stalls++;
      in_valid = (r == inject_idx);
      img_in = ~img;
      out_ready = rdy;
      tick();
      in_valid = 1'b0;
      if (rdy) r++;
      cyc++;
    end
    out_ready = 1'b0;
    check("stream_timeout", 256'(r), 256'(M));
    check("done_pulse", 256'(done), 256'(1));
    check("done_out_valid", 256'(out_valid), 256'(0));
    check("done_in_ready", 256'(in_ready), 256'(1));
    pooled = '0;
    for (int pr = 0; pr < N; pr++)
      for (int pc = 0; pc < N; pc++)
        pooled[pr*N+pc] = got_rows[2*pr][2*pc] | got_rows[2*pr][2*pc+1] |
                          got_rows[2*pr+1][2*pc] | got_rows[2*pr+1][2*pc+1];
    check("pool_roundtrip", 256'(pooled), 256'(img));
  endtask
  initial begin
    int cyc;
    img_t a, b;
    tick();
    tick();
    idle_checks("reset");
    rst_n = 1'b1;
    tick();
    check("post_reset_in_ready", 256'(in_ready), 256'(1));
    tbl.push_back('{img_t'(1), 0, 28'h0000003});
    tbl.push_back('{img_t'(1), 1, 28'h0000003});
    tbl.push_back('{img_t'(1), 2, 28'h0000000});
    tbl.push_back('{img_t'(1), 27, 28'h0000000});
    tbl.push_back('{img_t'(1) << 195, 26, 28'hC000000});
    tbl.push_back('{img_t'(1) << 195, 27, 28'hC000000});
    tbl.push_back('{img_t'(1) << 195, 25, 28'h0000000});
    tbl.push_back('{img_t'(1) << 195, 0, 28'h0000000});
    tbl.push_back('{~img_t'(0), 13, 28'hFFFFFFF});
    tbl.push_back('{rep_row(14'h1555), 5, 28'h3333333});
    tbl.push_back('{rep_row(14'h2AAA), 20, 28'hCCCCCCC});
    foreach (tbl[i]) begin
      send(tbl[i].img);
      stream(tbl[i].img, -1, 0, -1, -1, 1'b0, cyc);
      check("tbl_row", 256'(got_rows[tbl[i].idx]), 256'(tbl[i].row));
      check("tbl_cycles", 256'(cyc), 256'(M));
      tick();
      check("done_one_cycle", 256'(done), 256'(0));
    end
    send(checkerboard());
    stream(checkerboard(), 3, 5, -1, -1, 1'b0, cyc);
    check("backpressure_cycles", 256'(cyc), 256'(M + 5));
    a = rand_img();
    send(a);
    stream(a, -1, 0, 7, -1, 1'b0, cyc);
    tick();
    b = rand_img();
    send(b);
    stream(b, -1, 0, -1, 10, 1'b0, cyc);
    a = rand_img();
    send(a);
    stream(a, -1, 0, -1, -1, 1'b0, cyc);
    check("fresh_after_abort_cycles", 256'(cyc), 256'(M));
    a = rand_img();
    b = rand_img();
    send(a);
    stream(a, -1, 0, -1, -1, 1'b0, cyc);
    check("b2b_first_cycles", 256'(cyc), 256'(M));
    send(b);
    stream(b, -1, 0, -1, -1, 1'b0, cyc);
    check("b2b_second_cycles", 256'(cyc), 256'(M));
    for (int k = 0; k < 6; k++) begin
      a = rand_img();
      send(a);
      stream(a, -1, 0, -1, -1, 1'b1, cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
